// File: rtl/mul_init_pkg.sv
// mul_init_pkg: shared types and default sizes for mul_initiator.
// Optional watchdog in the top is enabled by defining MUL_INIT_TIMEOUT_EN.
package mul_init_pkg;

    localparam int unsigned MUL_W       = 4;
    localparam int unsigned MUL_MW      = 2 * MUL_W;
    localparam int unsigned MUL_DEPTH   = 2;
    localparam int unsigned MUL_TIMEOUT = 16;

    typedef struct packed {
        logic [MUL_W-1:0] b;
        logic [MUL_W-1:0] a;
    } pair_t;

    typedef logic [MUL_MW-1:0] result_t;

    function automatic pair_t mk_pair(
        input logic [MUL_W-1:0] a,
        input logic [MUL_W-1:0] b
    );
        pair_t p;
        p.a = a;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/mul_init_fifo.sv
// mul_init_fifo: circular result FIFO, wrap-bit pointers.
// p_depth must be a power of two, at least 2.
module mul_init_fifo
    import mul_init_pkg::*;
#(
    parameter int unsigned p_depth = MUL_DEPTH,
    parameter int unsigned p_dw    = MUL_MW,
    localparam int unsigned AW     = $clog2(p_depth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enq_i,
    input  logic [p_dw-1:0] enq_data_i,
    input  logic            deq_i,
    output logic [p_dw-1:0] deq_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [AW:0]     count_o
);

    logic [p_dw-1:0] mem_q [p_depth];
    logic [AW:0]     wptr_q;
    logic [AW:0]     rptr_q;

    // Pointers advance independently; the extra MSB tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (enq_i) wptr_q <= wptr_q + (AW+1)'(1);
            if (deq_i) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage has no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (enq_i) mem_q[wptr_q[AW-1:0]] <= enq_data_i;
    end

    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o    = wptr_q - rptr_q;
    assign deq_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mul_initiator.sv
// mul_initiator: credit-limited requester for the val/rdy multiply operator.
// Define MUL_INIT_TIMEOUT_EN to build the response watchdog driving err.
module mul_initiator
    import mul_init_pkg::*;
#(
    parameter int unsigned p_width   = MUL_W,
    parameter int unsigned p_depth   = MUL_DEPTH,
    parameter int unsigned p_timeout = MUL_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [p_width-1:0]   in_a,
    input  logic [p_width-1:0]   in_b,
    output logic                 req_val,
    input  logic                 req_rdy,
    output logic [2*p_width-1:0] req_msg,
    input  logic                 resp_val,
    output logic                 resp_rdy,
    input  logic [2*p_width-1:0] resp_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [2*p_width-1:0] out_msg,
    output logic                 err
);

    localparam int unsigned MW  = 2 * p_width;
    localparam int unsigned CW  = $clog2(p_depth + 1);
    localparam int unsigned FCW = $clog2(p_depth) + 1;

    logic          full_q;
    logic [MW-1:0] opnd_q;
    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] outst_q, outst_d;

    logic           in_go, req_go, resp_go, out_go;
    logic           fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_cnt;

    assign req_go  = req_val & req_rdy;
    assign in_rdy  = !full_q | req_go;
    assign in_go   = in_val & in_rdy;
    assign req_val = full_q & (credits_q != '0);
    assign req_msg = opnd_q;

    assign resp_rdy = (outst_q != '0) & !fifo_full;
    assign resp_go  = resp_val & resp_rdy;
    assign out_val  = !fifo_empty;
    assign out_go   = out_val & out_rdy;

    // One-entry operand register; refills in the cycle it issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            opnd_q <= '0;
        end else if (in_go) begin
            full_q <= 1'b1;
            opnd_q <= {in_b, in_a};
        end else if (req_go) begin
            full_q <= 1'b0;
        end
    end

    // Credits: spent on issue, returned when a result leaves the FIFO.
    always_comb begin
        credits_d = credits_q;
        unique case ({req_go, out_go})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Outstanding: requests issued but not yet answered.
    always_comb begin
        outst_d = outst_q;
        unique case ({req_go, resp_go})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Counter state; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_q <= CW'(p_depth);
            outst_q   <= '0;
        end else begin
            credits_q <= credits_d;
            outst_q   <= outst_d;
        end
    end

    mul_init_fifo #(
        .p_depth (p_depth),
        .p_dw    (MW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq_i      (resp_go),
        .enq_data_i (resp_msg),
        .deq_i      (out_go),
        .deq_data_o (out_msg),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

`ifdef MUL_INIT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(p_timeout + 1);

    logic [TW-1:0] wd_q, wd_d;
    logic          err_q;

    // Count idle cycles while waiting; saturate at the limit.
    always_comb begin
        wd_d = wd_q;
        if (resp_go || (outst_q == '0))
            wd_d = '0;
        else if (wd_q != TW'(p_timeout))
            wd_d = wd_q + TW'(1);
    end

    // Watchdog state; err is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_q | (wd_d == TW'(p_timeout));
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    a_no_full_outst : assert property (
        @(posedge clk) disable iff (!reset)
        !(fifo_full && (outst_q != '0))
    );

    a_credit_sum : assert property (
        @(posedge clk) disable iff (!reset)
        (32'(outst_q) + 32'(fifo_cnt) + 32'(credits_q)) == p_depth
    );

endmodule
